// File: rtl/proc_scan_ctrl.sv
// Frame scan controller: walks the frame buffer once, counts dominant-colour
// pixels per channel and reports the winning colour with a one-cycle done pulse.
module proc_scan_ctrl #(
   parameter int            AW       = 15,
   parameter int            DW       = 12,
   parameter int            IMA_SIZE = 19200,
   parameter logic [3:0]    THR      = 4'd8,
   parameter logic [14:0]   MIN_CNT  = 15'd1200
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          frame_ready,
   output logic [AW-1:0] proc_addr_in,
   input  logic [DW-1:0] proc_data_in,
   output logic          capture_hold,
   output logic          busy,
   output logic          done,
   output logic [1:0]    color_id,
   output logic [14:0]   cnt_r,
   output logic [14:0]   cnt_g,
   output logic [14:0]   cnt_b
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      SCAN,
      DRAIN,
      DECIDE,
      DONE
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(IMA_SIZE - 1);
   localparam logic [14:0]   CNT_MAX   = 15'h7FFF;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_addr;
   logic          r_pixValid;
   logic [14:0]   r_cntR;
   logic [14:0]   r_cntG;
   logic [14:0]   r_cntB;
   logic [1:0]    r_colorId;

   logic          w_startScan;
   logic          w_lastAddr;
   logic [3:0]    w_r;
   logic [3:0]    w_g;
   logic [3:0]    w_b;
   logic          w_isRed;
   logic          w_isGreen;
   logic          w_isBlue;
   logic [1:0]    w_winner;

   assign w_startScan = (r_state == IDLE) && start;
   assign w_lastAddr  = (r_state == SCAN) && (r_addr == LAST_ADDR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       if (start)       w_next = WAIT_FRAME;
         WAIT_FRAME: if (frame_ready) w_next = SCAN;
         SCAN:       if (w_lastAddr)  w_next = DRAIN;
         DRAIN:                       w_next = DECIDE;
         DECIDE:                      w_next = DONE;
         DONE:                        w_next = IDLE;
         default:                     w_next = IDLE;
      endcase
   end

   // Address is held at zero outside SCAN, so the reserved pixel is never read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= '0;
      end else if (w_next == SCAN) begin
         r_addr <= (r_state == SCAN) ? r_addr + 1'b1 : '0;
      end else begin
         r_addr <= '0;
      end
   end

   // Buffer read latency is one cycle, so classification trails the address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pixValid <= 1'b0;
      end else begin
         r_pixValid <= (r_state == SCAN);
      end
   end

   assign w_r = proc_data_in[11:8];
   assign w_g = proc_data_in[7:4];
   assign w_b = proc_data_in[3:0];

   assign w_isRed   = (w_r >= THR) && (w_r > w_g) && (w_r > w_b);
   assign w_isGreen = (w_g >= THR) && (w_g > w_r) && (w_g > w_b);
   assign w_isBlue  = (w_b >= THR) && (w_b > w_r) && (w_b > w_g);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cntR <= '0;
         r_cntG <= '0;
         r_cntB <= '0;
      end else if (w_startScan) begin
         r_cntR <= '0;
         r_cntG <= '0;
         r_cntB <= '0;
      end else if (r_pixValid) begin
         if (w_isRed && (r_cntR != CNT_MAX)) begin
            r_cntR <= r_cntR + 1'b1;
         end
         if (w_isGreen && (r_cntG != CNT_MAX)) begin
            r_cntG <= r_cntG + 1'b1;
         end
         if (w_isBlue && (r_cntB != CNT_MAX)) begin
            r_cntB <= r_cntB + 1'b1;
         end
      end
   end

   // A colour wins only with a strict majority over both others and enough pixels.
   always_comb begin
      w_winner = 2'd0;
      if ((r_cntR > r_cntG) && (r_cntR > r_cntB) && (r_cntR >= MIN_CNT)) begin
         w_winner = 2'd1;
      end else if ((r_cntG > r_cntR) && (r_cntG > r_cntB) && (r_cntG >= MIN_CNT)) begin
         w_winner = 2'd2;
      end else if ((r_cntB > r_cntR) && (r_cntB > r_cntG) && (r_cntB >= MIN_CNT)) begin
         w_winner = 2'd3;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_colorId <= 2'd0;
      end else if (r_state == DECIDE) begin
         r_colorId <= w_winner;
      end
   end

   assign proc_addr_in = r_addr;
   assign busy         = (r_state != IDLE);
   assign done         = (r_state == DONE);
   assign capture_hold = (r_state == SCAN) || (r_state == DRAIN) || (r_state == DECIDE);
   assign color_id     = r_colorId;
   assign cnt_r        = r_cntR;
   assign cnt_g        = r_cntG;
   assign cnt_b        = r_cntB;

endmodule

// File: tb/tb_proc_scan_ctrl.sv
// Scoreboard bench for proc_scan_ctrl: frame buffer model with one-cycle read
// latency, reference classifier, address/timing monitor and reset abort test.
module tb_proc_scan_ctrl;

   localparam int N = 19200;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        frame_ready = 1'b0;
   logic [14:0] proc_addr_in;
   logic [11:0] proc_data_in;
   logic        capture_hold;
   logic        busy;
   logic        done;
   logic [1:0]  color_id;
   logic [14:0] cnt_r;
   logic [14:0] cnt_g;
   logic [14:0] cnt_b;

   typedef struct {
      int r;
      int g;
      int b;
      int id;
   } exp_t;

   exp_t        sbQ[$];
   exp_t        lastExp;
   int          vectors = 0;
   int          miscompares = 0;
   logic [11:0] mem [0:N];

   proc_scan_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .frame_ready  (frame_ready),
      .proc_addr_in (proc_addr_in),
      .proc_data_in (proc_data_in),
      .capture_hold (capture_hold),
      .busy         (busy),
      .done         (done),
      .color_id     (color_id),
      .cnt_r        (cnt_r),
      .cnt_g        (cnt_g),
      .cnt_b        (cnt_b)
   );

   always #5 clk = ~clk;

   // Synchronous-read frame buffer: data appears the cycle after the address.
   always @(posedge clk) proc_data_in <= mem[proc_addr_in];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int classify(input logic [11:0] p);
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      r = p[11:8];
      g = p[7:4];
      b = p[3:0];
      if (r >= 4'd8 && r > g && r > b) return 1;
      if (g >= 4'd8 && g > r && g > b) return 2;
      if (b >= 4'd8 && b > r && b > g) return 3;
      return 0;
   endfunction

   task automatic fillFrame(input logic [11:0] lo, input logic [11:0] hi, input int split);
      for (int a = 0; a < N; a++) mem[a] = (a < split) ? lo : hi;
      mem[N] = 12'h000;
   endtask

   task automatic pushExpected();
      exp_t e;
      int   c;
      e.r = 0; e.g = 0; e.b = 0; e.id = 0;
      for (int a = 0; a < N; a++) begin
         c = classify(mem[a]);
         if (c == 1) e.r++;
         else if (c == 2) e.g++;
         else if (c == 3) e.b++;
      end
      if (e.r > e.g && e.r > e.b && e.r >= 1200) e.id = 1;
      else if (e.g > e.r && e.g > e.b && e.g >= 1200) e.id = 2;
      else if (e.b > e.r && e.b > e.g && e.b >= 1200) e.id = 3;
      sbQ.push_back(e);
   endtask

   task automatic checkResults(input string tag);
      if (sbQ.size() == 0) begin
         checkOutput({tag, "_unexpectedDone"}, 32'd1, 32'd0);
      end else begin
         lastExp = sbQ.pop_front();
         checkOutput({tag, "_cntR"}, cnt_r, lastExp.r);
         checkOutput({tag, "_cntG"}, cnt_g, lastExp.g);
         checkOutput({tag, "_cntB"}, cnt_b, lastExp.b);
         checkOutput({tag, "_colorId"}, color_id, lastExp.id);
      end
   endtask

   // One scan: start handshake, optional frame_ready delay, per-cycle monitor of
   // address/hold/done, optional start poke, frame_ready drop, abort or chaining.
   task automatic applyStimulus(input string tag, input int readyDelay, input int pokeAt,
                                input int dropAt, input int abortAt, input bit keepStart);
      bit chained;
      int addrErr = 0;
      int holdErr = 0;
      int doneErr = 0;
      int waitErr = 0;
      int maxAddr = 0;
      int doneAt = -1;
      int idleErr = 0;
      chained = start;
      start = 1'b1;
      frame_ready = (readyDelay == 0);
      if (chained) @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, "_waitBusy"}, busy, 32'd1);
      for (int i = 0; i < readyDelay; i++) begin
         if (capture_hold !== 1'b0 || proc_addr_in !== 15'd0 || busy !== 1'b1) waitErr++;
         @(negedge clk);
      end
      if (readyDelay > 0) checkOutput({tag, "_waitFrame"}, waitErr, 32'd0);
      frame_ready = 1'b1;
      if (abortAt < 0) pushExpected();
      for (int k = 0; k <= N + 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == pokeAt + 1) start = 1'b0;
         if (k == abortAt) begin
            checkOutput({tag, "_addrAtAbort"}, proc_addr_in, abortAt);
            rst = 1'b0;
            #1;
            checkOutput({tag, "_rstAddr"}, proc_addr_in, 32'd0);
            checkOutput({tag, "_rstHold"}, capture_hold, 32'd0);
            checkOutput({tag, "_rstBusy"}, busy, 32'd0);
            checkOutput({tag, "_rstDone"}, done, 32'd0);
            checkOutput({tag, "_rstColor"}, color_id, 32'd0);
            checkOutput({tag, "_rstCounts"}, {cnt_r, cnt_g, cnt_b} == 45'd0, 32'd1);
            @(negedge clk);
            rst = 1'b1;
            for (int i = 0; i < 30; i++) begin
               @(negedge clk);
               if (done !== 1'b0 || busy !== 1'b0 || capture_hold !== 1'b0) idleErr++;
            end
            checkOutput({tag, "_noRestart"}, idleErr, 32'd0);
            return;
         end
         if (proc_addr_in !== ((k < N) ? 15'(k) : 15'd0)) addrErr++;
         if (int'(proc_addr_in) > maxAddr) maxAddr = int'(proc_addr_in);
         if (capture_hold !== (k <= N + 1)) holdErr++;
         if (done === 1'b1) begin
            if (doneAt < 0) doneAt = k;
            else doneErr++;
            checkResults(tag);
         end
         if (k == pokeAt) start = 1'b1;
         if (k == dropAt) frame_ready = 1'b0;
         if (keepStart && k == N + 1) start = 1'b1;
      end
      checkOutput({tag, "_addrSeq"}, addrErr, 32'd0);
      checkOutput({tag, "_maxAddr"}, maxAddr, N - 1);
      checkOutput({tag, "_holdWindow"}, holdErr, 32'd0);
      checkOutput({tag, "_doneCycle"}, doneAt, N + 2);
      checkOutput({tag, "_doneWidth"}, doneErr, 32'd0);
      if (!keepStart) begin
         repeat (3) @(negedge clk);
         checkOutput({tag, "_idleBusy"}, busy, 32'd0);
         checkOutput({tag, "_holdColor"}, color_id, lastExp.id);
         checkOutput({tag, "_holdCntR"}, cnt_r, lastExp.r);
         checkOutput({tag, "_holdCntG"}, cnt_g, lastExp.g);
         checkOutput({tag, "_holdCntB"}, cnt_b, lastExp.b);
      end
   endtask

   initial begin
      fillFrame(12'hF00, 12'hF00, N);
      lastExp.r = 0; lastExp.g = 0; lastExp.b = 0; lastExp.id = 0;
      #1;
      checkOutput("reset_addr", proc_addr_in, 32'd0);
      checkOutput("reset_busy", busy, 32'd0);
      checkOutput("reset_hold", capture_hold, 32'd0);
      checkOutput("reset_done", done, 32'd0);
      checkOutput("reset_color", color_id, 32'd0);
      checkOutput("reset_counts", {cnt_r, cnt_g, cnt_b} == 45'd0, 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] abort at address 5000");
      applyStimulus("abort", 0, -1, -1, 5000, 1'b0);

      $display("[TB] all red, start pokes while busy");
      fillFrame(12'hF00, 12'hF00, N);
      applyStimulus("red", 0, 100, -1, -1, 1'b0);

      $display("[TB] green/blue split, frame_ready drop, start held through done");
      fillFrame(12'h0F0, 12'h00F, 10000);
      applyStimulus("grnBlu", 0, -1, 3000, -1, 1'b1);

      $display("[TB] below threshold and ties, delayed frame_ready");
      fillFrame(12'h777, 12'h880, 9600);
      applyStimulus("none", 50, -1, -1, -1, 1'b0);

      checkOutput("sbDrained", sbQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
